// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - serial bit-pattern detector fed by a byte handshake
// Bytes are serialised MSB first into a history register and compared against a latched pattern.
module seq_detect_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic [7:0] cfg_pattern,
   input  logic [2:0] cfg_len,
   input  logic       cfg_overlap,
   input  logic [7:0] cfg_limit,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   output logic       match_pulse,
   output logic [7:0] match_count,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WAIT_BYTE = 2'd1;
   localparam logic [1:0] SHIFT     = 2'd2;
   localparam logic [1:0] DONE      = 2'd3;

   logic [1:0] state_q,   state_d;
   logic [7:0] pattern_q, pattern_d;
   logic [2:0] len_q,     len_d;
   logic       overlap_q, overlap_d;
   logic [7:0] limit_q,   limit_d;
   logic [7:0] byte_q,    byte_d;
   logic [2:0] idx_q,     idx_d;
   logic [7:0] hist_q,    hist_d;
   logic [3:0] fill_q,    fill_d;
   logic [7:0] count_q,   count_d;
   logic       match_q,   match_d;

   logic [7:0] hist_shift;
   logic [7:0] mask;
   logic [3:0] fill_inc;
   logic       hit;

   // Match is judged on the history and fill count as they will be after this bit.
   always_comb begin
      hist_shift = {hist_q[6:0], byte_q[idx_q]};
      fill_inc   = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;
      mask       = 8'hFF >> (3'd7 - len_q);
      hit        = (fill_inc >= ({1'b0, len_q} + 4'd1)) &&
                   ((hist_shift & mask) == (pattern_q & mask));
   end

   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      len_d     = len_q;
      overlap_d = overlap_q;
      limit_d   = limit_q;
      byte_d    = byte_q;
      idx_d     = idx_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      count_d   = count_q;
      match_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               pattern_d = cfg_pattern;
               len_d     = cfg_len;
               overlap_d = cfg_overlap;
               limit_d   = cfg_limit;
               count_d   = 8'd0;
               hist_d    = 8'd0;
               fill_d    = 4'd0;
               state_d   = WAIT_BYTE;
            end
         end
         WAIT_BYTE: begin
            if (stop) begin
               state_d = IDLE;
            end else if (byte_valid) begin
               byte_d  = byte_data;
               idx_d   = 3'd7;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (stop) begin
               state_d = IDLE;
            end else begin
               hist_d = hist_shift;
               fill_d = fill_inc;
               idx_d  = idx_q - 3'd1;
               if (hit) begin
                  match_d = 1'b1;
                  if (count_q != 8'hFF) begin
                     count_d = count_q + 8'd1;
                  end
                  if (!overlap_q) begin
                     fill_d = 4'd0;
                  end
               end
               // Reaching the limit drops whatever bits remain in the current byte.
               if (hit && (limit_q != 8'd0) && (count_d == limit_q)) begin
                  state_d = DONE;
               end else if (idx_q == 3'd0) begin
                  state_d = WAIT_BYTE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         pattern_q <= 8'd0;
         len_q     <= 3'd0;
         overlap_q <= 1'b0;
         limit_q   <= 8'd0;
         byte_q    <= 8'd0;
         idx_q     <= 3'd0;
         hist_q    <= 8'd0;
         fill_q    <= 4'd0;
         count_q   <= 8'd0;
         match_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         len_q     <= len_d;
         overlap_q <= overlap_d;
         limit_q   <= limit_d;
         byte_q    <= byte_d;
         idx_q     <= idx_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         count_q   <= count_d;
         match_q   <= match_d;
      end
   end

   assign byte_ready  = (state_q == WAIT_BYTE);
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign match_pulse = match_q;
   assign match_count = count_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - randomized and directed bench for seq_detect_ctrl
// A bit-queue reference model is compared against the outputs on every falling edge.
module tb_seq_detect_ctrl;

   logic       clk;
   logic       reset;
   logic       start;
   logic       stop;
   logic [7:0] cfg_pattern;
   logic [2:0] cfg_len;
   logic       cfg_overlap;
   logic [7:0] cfg_limit;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_ready;
   logic       match_pulse;
   logic [7:0] match_count;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_on   = 0;

   seq_detect_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .stop        (stop),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cfg_limit   (cfg_limit),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .byte_ready  (byte_ready),
      .match_pulse (match_pulse),
      .match_count (match_count),
      .busy        (busy),
      .done        (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: run flag, bits left in the current byte, and a queue of recent bits.
   bit       m_run = 0;
   bit       m_fin = 0;
   int       m_left = 0;
   bit       m_hist[$];
   int       m_fill = 0;
   int       m_cnt = 0;
   bit       m_pulse = 0;
   bit       m_hit;
   logic [7:0] m_pat = 0;
   logic [7:0] m_byte = 0;
   int       m_n = 1;
   bit       m_ovl = 0;
   int       m_lim = 0;

   always @(posedge clk) begin
      if (!reset) begin
         m_run = 0; m_fin = 0; m_left = 0; m_hist.delete();
         m_fill = 0; m_cnt = 0; m_pulse = 0;
      end else begin
         m_pulse = 0;
         if (m_fin) begin
            m_fin = 0;
         end else if (!m_run) begin
            if (start && !stop) begin
               m_run = 1; m_left = 0; m_hist.delete(); m_fill = 0; m_cnt = 0;
               m_pat = cfg_pattern; m_n = int'(cfg_len) + 1;
               m_ovl = cfg_overlap; m_lim = int'(cfg_limit);
            end
         end else if (stop) begin
            m_run = 0; m_left = 0;
         end else if (m_left == 0) begin
            if (byte_valid) begin
               m_byte = byte_data;
               m_left = 8;
            end
         end else begin
            m_hist.push_back(m_byte[m_left-1]);
            if (m_hist.size() > 8) void'(m_hist.pop_front());
            m_left--;
            if (m_fill < 8) m_fill++;
            m_hit = (m_fill >= m_n);
            if (m_hit) begin
               for (int k = 0; k < m_n; k++) begin
                  if (m_hist[m_hist.size()-1-k] != m_pat[k]) m_hit = 0;
               end
            end
            if (m_hit) begin
               m_pulse = 1;
               if (m_cnt < 255) m_cnt++;
               if (!m_ovl) m_fill = 0;
               if (m_lim != 0 && m_cnt == m_lim) begin
                  m_run = 0; m_fin = 1; m_left = 0;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("busy",        busy,        32'(m_run || m_fin));
         chk("byte_ready",  byte_ready,  32'(m_run && m_left == 0));
         chk("done",        done,        32'(m_fin));
         chk("match_pulse", match_pulse, 32'(m_pulse));
         chk("match_count", match_count, 32'(m_cnt));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
   endtask

   task automatic start_run(input logic [7:0] pat, input logic [2:0] len,
                            input logic ovl, input logic [7:0] lim);
      cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_limit = lim;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_data  = b;
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic shift8(output int lowc, output logic [7:0] pmask);
      lowc  = byte_ready ? 0 : 1;
      pmask = 8'd0;
      for (int j = 0; j < 8; j++) begin
         tick();
         pmask[j] = match_pulse;
         if (!byte_ready) lowc++;
      end
   endtask

   int         lowc;
   logic [7:0] pmask;

   initial begin
      reset = 1'b0; start = 1'b0; stop = 1'b0;
      cfg_pattern = 8'd0; cfg_len = 3'd0; cfg_overlap = 1'b0; cfg_limit = 8'd0;
      byte_valid = 1'b0; byte_data = 8'd0;
      tick();
      chk_on = 1;
      tick();
      chk("rst_busy",  busy,        0);
      chk("rst_ready", byte_ready,  0);
      chk("rst_count", match_count, 0);
      chk("rst_pulse", match_pulse, 0);
      chk("rst_done",  done,        0);
      reset = 1'b1;
      tick();

      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("start_stop_idle", busy, 0);

      // Overlapping 1011 in 0xB6: matches end at bits 4 and 7.
      start_run(8'h0B, 3'd3, 1'b1, 8'd0);
      chk("run_busy",  busy,       1);
      chk("run_ready", byte_ready, 1);
      send_byte(8'hB6);
      shift8(lowc, pmask);
      chk("ovl_pulses", pmask, 8'h48);
      chk("ovl_count",  match_count, 2);
      go_idle();
      chk("ovl_kept_count", match_count, 2);

      start_run(8'h0B, 3'd3, 1'b0, 8'd0);
      send_byte(8'hB6);
      shift8(lowc, pmask);
      chk("novl_pulses", pmask, 8'h08);
      chk("novl_count",  match_count, 1);
      go_idle();

      // Limit of one: done in the cycle after the fourth bit, idle one cycle later.
      start_run(8'h0B, 3'd3, 1'b1, 8'd1);
      send_byte(8'hB6);
      for (int j = 0; j < 4; j++) tick();
      chk("lim_pulse", match_pulse, 1);
      chk("lim_done",  done,        1);
      chk("lim_count", match_count, 1);
      tick();
      chk("lim_busy_off", busy, 0);
      chk("lim_done_off", done, 0);
      for (int j = 0; j < 4; j++) tick();
      chk("lim_count_hold", match_count, 1);

      // Match spanning 0x01 -> 0x60 with byte_valid held high.
      start_run(8'h0B, 3'd3, 1'b1, 8'd0);
      byte_valid = 1'b1;
      byte_data  = 8'h01;
      tick();
      shift8(lowc, pmask);
      chk("span_low1",   lowc,  8);
      chk("span_pulse1", pmask, 8'h00);
      chk("span_ready",  byte_ready, 1);
      byte_data = 8'h60;
      tick();
      shift8(lowc, pmask);
      byte_valid = 1'b0;
      chk("span_low2",   lowc,  8);
      chk("span_pulse2", pmask, 8'h04);
      chk("span_count",  match_count, 1);
      go_idle();

      // Stop on the cycle that would shift the matching bit.
      start_run(8'h0B, 3'd3, 1'b1, 8'd0);
      send_byte(8'hB6);
      for (int j = 0; j < 3; j++) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_pulse", match_pulse, 0);
      chk("stop_count", match_count, 0);
      chk("stop_busy",  busy,        0);
      chk("stop_done",  done,        0);

      // Reset in the middle of a byte after one match.
      start_run(8'h0B, 3'd3, 1'b1, 8'd0);
      send_byte(8'hB6);
      for (int j = 0; j < 4; j++) tick();
      chk("pre_rst_count", match_count, 1);
      reset = 1'b0;
      tick();
      chk("mid_rst_busy",  busy,        0);
      chk("mid_rst_ready", byte_ready,  0);
      chk("mid_rst_count", match_count, 0);
      chk("mid_rst_pulse", match_pulse, 0);
      reset = 1'b1;
      tick();
      chk("post_rst_pulse", match_pulse, 0);
      chk("post_rst_done",  done,        0);

      for (int i = 0; i < 4000; i++) begin
         reset       = ($urandom_range(0, 299) != 0);
         start       = ($urandom_range(0, 7) == 0);
         stop        = ($urandom_range(0, 39) == 0);
         cfg_pattern = 8'($urandom);
         cfg_len     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                   : 3'($urandom_range(0, 2));
         cfg_overlap = 1'($urandom_range(0, 1));
         cfg_limit   = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
         byte_valid  = ($urandom_range(0, 1) == 0);
         byte_data   = 8'($urandom);
         tick();
      end

      reset = 1'b1; start = 1'b0; stop = 1'b0; byte_valid = 1'b0;
      tick();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 SHALL have parameter: none; all configuration is by port and latched at start.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  one-cycle pulse; begins a detection run (honoured only in IDLE).
REQ-005 SHALL have port stop  input  1  aborts the current run.
REQ-006 SHALL have port cfg_pattern  input  8  target pattern, LSB-aligned; the newest bit is compared against bit 0.
REQ-007 SHALL have port cfg_len  input  3  pattern length minus 1 (1..8 bits).
REQ-008 SHALL have port cfg_overlap  input  1  1 = overlapping matches allowed.
REQ-009 SHALL have port cfg_limit  input  8  number of matches that ends the run; 0 = unlimited.
REQ-010 SHALL have port byte_valid  input  1  input byte available.
REQ-011 SHALL have port byte_data  input  8  input byte, serialised MSB first.
REQ-012 SHALL have port byte_ready  output  1  byte is accepted when byte_valid and byte_ready are both high.
REQ-013 SHALL have port match_pulse  output  1  registered; one-cycle pulse per match.
REQ-014 SHALL have port match_count  output  8  matches in the current or last run; saturates at 255.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse when cfg_limit is reached.

Function
REQ-017 SHALL implement states IDLE, WAIT_BYTE, SHIFT and DONE.
REQ-018 SHALL, in IDLE on start, latch cfg_*, clear match_count, history register and fill counter, and go to WAIT_BYTE.
REQ-019 SHALL drive byte_ready high only in WAIT_BYTE; on handshake, latch byte_data, set bit index to 7 and go to SHIFT.
REQ-020 SHALL, in SHIFT, shift one bit per cycle (index 7 down to 0) into history as new bit 0, incrementing fill counter (saturating at 8).
REQ-021 SHALL, after bit 0 with no limit hit, return to WAIT_BYTE; throughput is 9 cycles per byte.
REQ-022 SHALL detect a match when fill counter >= cfg_len+1 and the low cfg_len+1 bits of updated history equal those of cfg_pattern.
REQ-023 SHALL assert match_pulse in the cycle after the edge that shifted in the matching bit, and increment match_count (saturating) on that edge.
REQ-024 SHALL, with cfg_overlap=0, clear the fill counter on a match; with cfg_overlap=1, leave it unchanged.
REQ-025 SHALL preserve history and fill counter across byte boundaries, so matches may span bytes.
REQ-026 SHALL, when cfg_limit is nonzero and match_count reaches it, go to DONE, discarding the remaining bits of the byte.
REQ-027 SHALL pulse done for one cycle in DONE, then go to IDLE.
REQ-028 SHALL, on stop in any non-IDLE state, go to IDLE on the next edge, discard the partial byte, retain match_count and not pulse done.
REQ-029 SHALL give stop priority over a same-cycle bit shift: no bit processed, no match, no done.
REQ-030 SHALL ignore start while busy; start and stop together in IDLE SHALL be ignored.
REQ-031 SHALL retain match_count in IDLE until the next start or reset.

Reset
REQ-032 SHALL, while reset=0 at a rising edge, force state=IDLE, byte_ready=0, busy=0, match_pulse=0, done=0, match_count=0, history=0 and fill counter=0.
REQ-033 SHALL abort any run mid-byte on reset, with no done or match_pulse after release.

Verification
REQ-034 Reset mid-SHIFT -> next cycle busy=0, byte_ready=0, match_count=0, no pulses.
REQ-035 cfg_pattern=0x0B, cfg_len=3, cfg_overlap=1, cfg_limit=0, byte 0xB6 -> match_pulse after bits 4 and 7, match_count=2.
REQ-036 Same as REQ-035 with cfg_overlap=0 -> one match_pulse after bit 4, match_count=1.
REQ-037 Same as REQ-035 with cfg_limit=1 -> done pulse after first match, match_count=1, busy=0 two cycles later, remaining bits not shifted.
REQ-038 Bytes 0x01 then 0x60 with byte_valid held high, pattern 1011 -> byte_ready low for 8 SHIFT cycles between handshakes; one match at bit 3 of the second byte (match spans the byte boundary).
REQ-039 stop asserted on the same cycle as a matching bit -> no match_pulse, match_count unchanged, IDLE next cycle, done=0.
